wm8731_config_sequencer: RTL and testbench

//  Power-up configuration controller for the WM8731 codec control port (3-wire mode, MODE=1).
//  On a start pulse it walks a fixed table of 16-bit register words ({addr[6:0], data[8:0]}).

---
 rtl/wm8731_cfg_pkg.sv | 24 ++
 rtl/wm8731_config_rom.sv | 31 +++
 rtl/wm8731_config_sequencer.sv | 155 +++++++++++++++
 tb/tb_wm8731_config_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_cfg_pkg.sv
// Shared types and register map for the WM8731 3-wire configuration sequencer.
package wm8731_cfg_pkg;

  typedef logic [15:0] cfg_word_t;

  localparam logic [6:0] R0_LLINE  = 7'd0;
  localparam logic [6:0] R1_RLINE  = 7'd1;
  localparam logic [6:0] R2_LHP    = 7'd2;
  localparam logic [6:0] R3_RHP    = 7'd3;
  localparam logic [6:0] R4_APATH  = 7'd4;
  localparam logic [6:0] R5_DPATH  = 7'd5;
  localparam logic [6:0] R6_PWR    = 7'd6;
  localparam logic [6:0] R7_IFACE  = 7'd7;
  localparam logic [6:0] R8_SRATE  = 7'd8;
  localparam logic [6:0] R9_ACTIVE = 7'd9;
  localparam logic [6:0] R15_RESET = 7'd15;

  typedef enum logic [2:0] {StIdle, StLoad, StLow, StHigh, StHold, StGap} state_e;

  function automatic cfg_word_t cfg_word(input logic [6:0] addr, input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/wm8731_config_rom.sv
// Fixed power-up register table for the WM8731; entries past NUM_WORDS read as zero.
module wm8731_config_rom
  import wm8731_cfg_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 11
) (
  input  logic [3:0] index,
  output cfg_word_t  word
);

  always_comb begin
    word = '0;
    if (32'(index) < NUM_WORDS) begin
      case (index)
        4'd0:    word = cfg_word(R15_RESET, 9'h000);
        4'd1:    word = cfg_word(R6_PWR,    9'h000);
        4'd2:    word = cfg_word(R0_LLINE,  9'h017);
        4'd3:    word = cfg_word(R1_RLINE,  9'h017);
        4'd4:    word = cfg_word(R2_LHP,    9'h079);
        4'd5:    word = cfg_word(R3_RHP,    9'h079);
        4'd6:    word = cfg_word(R4_APATH,  9'h012);
        4'd7:    word = cfg_word(R5_DPATH,  9'h000);
        4'd8:    word = cfg_word(R7_IFACE,  9'h002);
        4'd9:    word = cfg_word(R8_SRATE,  9'h000);
        4'd10:   word = cfg_word(R9_ACTIVE, 9'h001);
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/wm8731_config_sequencer.sv
// Walks the codec register table once per accepted start, shifting each word out on SCLK/SDIN
// and latching it with a CSB rising edge. Every pin is driven straight from a flop.
module wm8731_config_sequencer
  import wm8731_cfg_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 11,
  parameter int unsigned CLK_DIV   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       sclk,
  output logic       sdin,
  output logic       csb,
  output logic       busy,
  output logic       done,
  output logic [3:0] word_index
);

  localparam int unsigned    DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [3:0]      LastIdx = 4'(NUM_WORDS - 1);

  state_e          r_state, w_state_d;
  logic [DivW-1:0] r_div_cnt, w_div_cnt_d;
  logic [3:0]      r_bit_cnt, w_bit_cnt_d;
  cfg_word_t       r_shreg, w_shreg_d;
  logic [3:0]      r_word_index, w_word_index_d;
  logic            r_sclk, w_sclk_d;
  logic            r_sdin, w_sdin_d;
  logic            r_csb, w_csb_d;
  logic            r_busy, w_busy_d;
  logic            r_done, w_done_d;
  cfg_word_t       w_rom_word;
  logic            w_phase_end;

  wm8731_config_rom #(
    .NUM_WORDS(NUM_WORDS)
  ) u_rom (
    .index(r_word_index),
    .word (w_rom_word)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_word_index <= '0;
      r_sclk       <= 1'b0;
      r_sdin       <= 1'b0;
      r_csb        <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_div_cnt    <= w_div_cnt_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_shreg      <= w_shreg_d;
      r_word_index <= w_word_index_d;
      r_sclk       <= w_sclk_d;
      r_sdin       <= w_sdin_d;
      r_csb        <= w_csb_d;
      r_busy       <= w_busy_d;
      r_done       <= w_done_d;
    end
  end

  assign w_phase_end = (r_div_cnt == DivLast);

  always_comb begin
    w_state_d      = r_state;
    w_div_cnt_d    = '0;
    w_bit_cnt_d    = r_bit_cnt;
    w_shreg_d      = r_shreg;
    w_word_index_d = r_word_index;
    w_sclk_d       = r_sclk;
    w_sdin_d       = r_sdin;
    w_csb_d        = r_csb;
    w_busy_d       = r_busy;
    w_done_d       = r_done;

    // Timed phases share one divider that restarts at every phase boundary.
    if (r_state inside {StLow, StHigh, StHold, StGap}) begin
      w_div_cnt_d = w_phase_end ? '0 : r_div_cnt + DivW'(1);
    end

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d      = StLoad;
          w_done_d       = 1'b0;
          w_word_index_d = '0;
          w_busy_d       = 1'b1;
        end
      end
      StLoad: begin
        w_shreg_d   = w_rom_word;
        w_bit_cnt_d = 4'd15;
        w_sdin_d    = w_rom_word[15];
        w_csb_d     = 1'b0;
        w_state_d   = StLow;
      end
      StLow: begin
        if (w_phase_end) begin
          w_sclk_d  = 1'b1;
          w_state_d = StHigh;
        end
      end
      StHigh: begin
        if (w_phase_end) begin
          w_sclk_d = 1'b0;
          if (r_bit_cnt == 4'd0) begin
            w_state_d = StHold;
          end else begin
            // Next bit goes out as LOW is entered so it is stable across the following HIGH.
            w_shreg_d   = {r_shreg[14:0], 1'b0};
            w_sdin_d    = r_shreg[14];
            w_bit_cnt_d = r_bit_cnt - 4'd1;
            w_state_d   = StLow;
          end
        end
      end
      StHold: begin
        if (w_phase_end) begin
          w_csb_d   = 1'b1;
          w_state_d = StGap;
        end
      end
      StGap: begin
        if (w_phase_end) begin
          w_word_index_d = r_word_index + 4'd1;
          if (r_word_index == LastIdx) begin
            w_state_d = StIdle;
            w_busy_d  = 1'b0;
            w_done_d  = 1'b1;
            w_sdin_d  = 1'b0;
          end else begin
            w_state_d = StLoad;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign sclk       = r_sclk;
  assign sdin       = r_sdin;
  assign csb        = r_csb;
  assign busy       = r_busy;
  assign done       = r_done;
  assign word_index = r_word_index;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Directed bench: decodes the serial stream like the codec would and checks words, timing and
// pin-ordering rules on a default instance and on a CLK_DIV=1 instance.
module tb_wm8731_config_sequencer;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sclk, sdin, csb, busy, done;
  logic [3:0] word_index;

  logic       f_start;
  logic       f_sclk, f_sdin, f_csb, f_busy, f_done;
  logic [3:0] f_word_index;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_words [11];

  always #5 clock = ~clock;

  wm8731_config_sequencer dut (
    .clock     (clock),
    .reset     (rst_n),
    .start     (start),
    .sclk      (sclk),
    .sdin      (sdin),
    .csb       (csb),
    .busy      (busy),
    .done      (done),
    .word_index(word_index)
  );

  wm8731_config_sequencer #(
    .NUM_WORDS(11),
    .CLK_DIV  (1)
  ) dut_fast (
    .clock     (clock),
    .reset     (rst_n),
    .start     (f_start),
    .sclk      (f_sclk),
    .sdin      (f_sdin),
    .csb       (f_csb),
    .busy      (f_busy),
    .done      (f_done),
    .word_index(f_word_index)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Codec-side decoder for the default instance.
  logic [15:0] m_words [$];
  int          m_rise_q [$];
  logic [15:0] m_sh = '0;
  int          m_rises = 0;
  int          m_viol = 0;
  logic        m_prev_sclk = 1'b0, m_prev_sdin = 1'b0, m_prev_csb = 1'b1, m_prev_rst = 1'b0;

  always @(negedge clock) begin
    if (rst_n && m_prev_rst) begin
      if (m_prev_sclk && sclk && (sdin !== m_prev_sdin)) m_viol++;
      if ((m_prev_sclk || sclk) && (csb !== m_prev_csb)) m_viol++;
    end
    if (!m_prev_sclk && sclk) begin
      m_sh = {m_sh[14:0], sdin};
      m_rises++;
    end
    if (m_prev_csb && !csb) m_rises = 0;
    if (!m_prev_csb && csb) begin
      m_words.push_back(m_sh);
      m_rise_q.push_back(m_rises);
    end
    m_prev_sclk = sclk;
    m_prev_sdin = sdin;
    m_prev_csb  = csb;
    m_prev_rst  = rst_n;
  end

  // Decoder plus timing probes for the CLK_DIV=1 instance.
  logic [15:0] f_words [$];
  int          f_low_q [$];
  logic [15:0] f_sh = '0;
  int          f_cyc = 0, f_low = 0, f_last_fall = 0, f_span = 0;
  int          f_last_rise = 0, f_rise_in_win = 0, f_bad_period = 0;
  logic        f_prev_sclk = 1'b0, f_prev_csb = 1'b1;

  always @(negedge clock) begin
    f_cyc++;
    if (f_prev_csb && !f_csb) begin
      if (f_last_fall > 0) f_span = f_cyc - f_last_fall;
      f_last_fall   = f_cyc;
      f_low         = 0;
      f_rise_in_win = 0;
    end
    if (!f_csb) f_low++;
    if (!f_prev_sclk && f_sclk) begin
      f_sh = {f_sh[14:0], f_sdin};
      if (f_rise_in_win > 0 && (f_cyc - f_last_rise) != 2) f_bad_period++;
      f_last_rise = f_cyc;
      f_rise_in_win++;
    end
    if (!f_prev_csb && f_csb) begin
      f_words.push_back(f_sh);
      f_low_q.push_back(f_low);
    end
    f_prev_sclk = f_sclk;
    f_prev_csb  = f_csb;
  end

  task automatic clear_mon();
    m_words.delete();
    m_rise_q.delete();
    m_viol = 0;
  endtask

  task automatic check_words(input string tag);
    check({tag, "_count"}, 32'(m_words.size()), 11);
    for (int i = 0; i < 11 && i < m_words.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), 32'(m_words[i]), 32'(exp_words[i]));
      check($sformatf("%s_rises%0d", tag, i), 32'(m_rise_q[i]), 16);
    end
    check({tag, "_order_rules"}, 32'(m_viol), 0);
  endtask

  task automatic run(input int pulse_at, output int cycles);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    cycles = 0;
    check("busy_after_start", 32'(busy), 1);
    check("done_cleared", 32'(done), 0);
    while (!done && cycles < 3000) begin
      @(posedge clock);
      #1;
      cycles++;
      start = (cycles == pulse_at);
    end
    start = 1'b0;
    check("run_len", 32'(cycles), 1507);
    check("end_index", 32'(word_index), 11);
    check("busy_end", 32'(busy), 0);
  endtask

  initial begin
    int cyc;
    exp_words = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                  16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};
    rst_n   = 1'b0;
    start   = 1'b0;
    f_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sdin", 32'(sdin), 0);
    check("rst_csb", 32'(csb), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_index", 32'(word_index), 0);
    @(negedge clock);
    rst_n = 1'b1;

    // CLK_DIV=1 instance: 35-cycle words, 33-cycle csb-low windows, 2-cycle sclk period.
    @(negedge clock);
    f_start = 1'b1;
    @(posedge clock);
    #1;
    f_start = 1'b0;
    cyc = 0;
    while (!f_done && cyc < 1000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("fast_run_len", 32'(cyc), 385);
    check("fast_count", 32'(f_words.size()), 11);
    if (f_words.size() > 0) check("fast_word0", 32'(f_words[0]), 32'h1E00);
    for (int i = 0; i < f_low_q.size(); i++) check("fast_csb_low", 32'(f_low_q[i]), 33);
    check("fast_span", 32'(f_span), 35);
    check("fast_sclk_period", 32'(f_bad_period), 0);

    // Plain run.
    clear_mon();
    run(-1, cyc);
    check_words("run1");

    // Extra start at cycle 300 while busy must be ignored.
    clear_mon();
    run(300, cyc);
    check_words("busy_start");

    // Reset at cycle 70, mid word 0.
    clear_mon();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (70) @(posedge clock);
    #1;
    check("mid_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_csb", 32'(csb), 1);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_index", 32'(word_index), 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    clear_mon();
    run(-1, cyc);
    check_words("after_rst");

    // start held high: back-to-back runs with a one-cycle done pulse between them.
    clear_mon();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("held_run_len", 32'(cyc), 1507);
    check_words("held_run1");
    clear_mon();
    @(posedge clock);
    #1;
    check("held_done_pulse", 32'(done), 0);
    check("held_busy_again", 32'(busy), 1);
    check("held_index_restart", 32'(word_index), 0);
    cyc = 0;
    while (m_words.size() == 0 && cyc < 500) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("held_run2_first_count", 32'(m_words.size()), 1);
    if (m_words.size() > 0) check("held_run2_word0", 32'(m_words[0]), 32'h1E00);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check("held_run2_done", 32'(done), 1);
    check("held_run2_count", 32'(m_words.size()), 11);
    check("held_run2_rules", 32'(m_viol), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
